// File: rtl/ysyx_22041461_pkg.sv
// Shared types and constants for the I/D refill arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ysyx_22041461_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_22041461_rr_arb2.sv
// 2-way round-robin arbiter: one-hot grant from two request bits, pointer register.
// Latency: grant is combinational; pointer moves the cycle after the update pulse.
// Backpressure: grant only while enabled; pointer flips away from the last winner on update.
module ysyx_22041461_rr_arb2
  import ysyx_22041461_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,     // bit0 = ICACHE, bit1 = DCACHE
  input  logic       i_en,
  input  logic       i_update,  // end of the granted transaction
  output logic [1:0] o_gnt,
  output logic       o_ptr      // owner currently favoured on contention
);

  logic r_ptr;
  logic r_won;  // owner of the most recent grant, used when the pointer moves

  // Grant the only requester, or the favoured one when both ask.
  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        o_gnt = (r_ptr == OWNER_D) ? 2'b10 : 2'b01;
      end else begin
        o_gnt = i_req;
      end
    end
  end

  // Remember the winner and hand priority to the other side once it is done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= OWNER_I;
      r_won <= OWNER_I;
    end else begin
      if (|o_gnt) begin
        r_won <= o_gnt[1];
      end
      if (i_update) begin
        r_ptr <= ~r_won;
      end
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ysyx_22041461_refill_arbiter.sv
// Shares one AR/R read channel between ICACHE and DCACHE refills, one burst at a time.
// Latency: request accepted at t -> ar_valid at t+1; R beats reach the owner combinationally.
// Backpressure: one outstanding burst; requesters must accept every beat (no resp backpressure).
module ysyx_22041461_refill_arbiter
  import ysyx_22041461_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [LEN_W-1:0]  i_req_len,
  output logic              i_req_ready,
  output logic              i_resp_valid,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LEN_W-1:0]  d_req_len,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              resp_err,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [LEN_W-1:0]  ar_len,
  output logic              ar_id,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic              r_last,
  input  logic [1:0]        r_resp
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic                r_owner;
  logic [LEN_W:0]      r_cnt;
  logic                r_err;

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_ptr;
  logic                w_arb_en;
  logic                w_owner_nxt;
  logic                w_beat;
  logic                w_last_beat;
  logic                w_beat_err;

  assign w_req    = {d_req_valid, i_req_valid};
  // Keep req_ready low while reset is held, even though the state already reads IDLE.
  assign w_arb_en = (r_state == IDLE) && !rst;

  ysyx_22041461_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_en     (w_arb_en),
    .i_update (w_last_beat),
    .o_gnt    (w_gnt),
    .o_ptr    (w_ptr)
  );

  // On contention the owner is whoever the pointer favours, otherwise the lone requester.
  assign w_owner_nxt = (&w_req) ? w_ptr : w_req[1];

  // Next state and per-state handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    ar_valid    = 1'b0;
    r_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_gnt) w_state_nxt = ADDR;
      end
      ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) w_state_nxt = DATA;
      end
      DATA: begin
        r_ready = 1'b1;
        if (r_valid && r_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Capture the winning request so AR stays stable until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_owner <= OWNER_I;
    end else if (|w_gnt) begin
      r_addr  <= w_gnt[1] ? d_req_addr : i_req_addr;
      r_len   <= w_gnt[1] ? d_req_len  : i_req_len;
      r_owner <= w_owner_nxt;
    end
  end

  assign w_beat      = (r_state == DATA) && r_valid;
  assign w_last_beat = w_beat && r_last;

  // A beat is bad on a non-OKAY response, an early/late last, or running past len.
  assign w_beat_err = (r_resp != RESP_OKAY) ||
                      (r_last ? (r_cnt != {1'b0, r_len}) : (r_cnt >= {1'b0, r_len}));

  // Beat counter and sticky error flag, both scoped to one burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if ((r_state == ADDR) && ar_ready) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_beat) begin
      if (r_last) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        r_cnt <= r_cnt + (LEN_W+1)'(1);
        r_err <= r_err | w_beat_err;
      end
    end
  end

  assign i_req_ready  = w_gnt[0];
  assign d_req_ready  = w_gnt[1];
  assign ar_addr      = r_addr;
  assign ar_len       = r_len;
  assign ar_id        = r_owner;
  assign i_resp_valid = w_beat && (r_owner == OWNER_I);
  assign d_resp_valid = w_beat && (r_owner == OWNER_D);
  assign resp_data    = w_beat ? r_data : '0;
  assign resp_last    = w_last_beat;
  assign resp_err     = w_last_beat && (r_err || w_beat_err);

endmodule

// File: tb/tb_ysyx_22041461_refill_arbiter.sv
// Directed bench for the I/D refill arbiter with a beat scoreboard.
// Latency: drives after the rising edge, samples on the falling edge.
// Backpressure: responses are consumed every cycle; ar_ready is stalled on demand.
module tb_ysyx_22041461_refill_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req_valid, d_req_valid;
  logic [63:0] i_req_addr, d_req_addr;
  logic [7:0]  i_req_len, d_req_len;
  logic        i_req_ready, d_req_ready;
  logic        i_resp_valid, d_resp_valid;
  logic [63:0] resp_data;
  logic        resp_last, resp_err;
  logic        ar_valid, ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic        ar_id;
  logic        r_valid, r_ready;
  logic [63:0] r_data;
  logic        r_last;
  logic [1:0]  r_resp;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        own;
    logic [63:0] data;
    logic        last;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;

  ysyx_22041461_refill_arbiter #(.ADDR_W(64), .DATA_W(64), .LEN_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .i_req_addr   (i_req_addr),
    .i_req_len    (i_req_len),
    .i_req_ready  (i_req_ready),
    .i_resp_valid (i_resp_valid),
    .d_req_valid  (d_req_valid),
    .d_req_addr   (d_req_addr),
    .d_req_len    (d_req_len),
    .d_req_ready  (d_req_ready),
    .d_resp_valid (d_resp_valid),
    .resp_data    (resp_data),
    .resp_last    (resp_last),
    .resp_err     (resp_err),
    .ar_valid     (ar_valid),
    .ar_ready     (ar_ready),
    .ar_addr      (ar_addr),
    .ar_len       (ar_len),
    .ar_id        (ar_id),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_data       (r_data),
    .r_last       (r_last),
    .r_resp       (r_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid,
                            resp_last, resp_err, ar_valid, ar_id, r_ready}), 64'd0);
    chk({tag, "_data"}, resp_data, 64'd0);
    chk({tag, "_ar"}, ar_addr | 64'(ar_len), 64'd0);
  endtask

  // Scoreboard: every falling edge with a pending or produced beat is compared.
  always @(negedge clk) begin
    if (!rst && (exp_q.size() > 0 || i_resp_valid || d_resp_valid)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'({i_resp_valid, d_resp_valid}), 64'd0);
      end else begin
        m_e = exp_q.pop_front();
        chk("i_resp_valid", 64'(i_resp_valid), 64'(!m_e.own));
        chk("d_resp_valid", 64'(d_resp_valid), 64'(m_e.own));
        chk("resp_data", resp_data, m_e.data);
        chk("resp_last", 64'(resp_last), 64'(m_e.last));
        chk("resp_err", 64'(resp_err), 64'(m_e.err));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One refill: request, optional AR stall, beats; bad = beat with SLVERR, abort = beat hit by reset.
  task automatic txn(input logic iv, input logic dv, input logic own,
                     input logic [63:0] addr, input logic [7:0] len, input int nbeats,
                     input logic [63:0] base, input int bad, input int stall, input int abort);
    logic [63:0] ea;
    exp_t e;
    ea = own ? addr + 64'h1000 : addr;
    i_req_addr  = addr;
    d_req_addr  = addr + 64'h1000;
    i_req_len   = len;
    d_req_len   = len;
    i_req_valid = iv;
    d_req_valid = dv;
    @(negedge clk);
    chk("i_req_ready", 64'(i_req_ready), 64'(!own));
    chk("d_req_ready", 64'(d_req_ready), 64'(own));
    @(posedge clk); #1;
    if (own) d_req_valid = 1'b0;
    else     i_req_valid = 1'b0;
    ar_ready = (stall == 0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_ar_valid", 64'(ar_valid), 64'd1);
      chk("stall_ar_addr", ar_addr, ea);
      chk("stall_ar_len", 64'(ar_len), 64'(len));
      chk("stall_r_ready", 64'(r_ready), 64'd0);
      @(posedge clk); #1;
    end
    ar_ready = 1'b1;
    @(negedge clk);
    chk("ar_valid", 64'(ar_valid), 64'd1);
    chk("ar_id", 64'(ar_id), 64'(own));
    chk("ar_addr", ar_addr, ea);
    chk("ar_len", 64'(ar_len), 64'(len));
    chk("addr_r_ready", 64'(r_ready), 64'd0);
    chk("addr_req_ready", 64'({i_req_ready, d_req_ready}), 64'd0);
    @(posedge clk); #1;
    for (int b = 0; b < nbeats; b++) begin
      r_valid = 1'b1;
      r_data  = base * 64'(b + 1);
      r_last  = (b == nbeats - 1);
      r_resp  = (b == bad) ? 2'b10 : 2'b00;
      if (b == abort) begin
        rst = 1'b1;
        #1;
        chk_zero("reset_mid_burst");
        @(posedge clk); #1;
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_resp  = 2'b00;
        rst     = 1'b0;
        return;
      end
      e.own  = own;
      e.data = r_data;
      e.last = r_last;
      e.err  = r_last && (bad >= 0 || nbeats != int'(len) + 1);
      exp_q.push_back(e);
      @(negedge clk);
      chk("data_r_ready", 64'(r_ready), 64'd1);
      chk("data_ar_valid", 64'(ar_valid), 64'd0);
      @(posedge clk); #1;
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    r_resp  = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    i_req_addr = '0; d_req_addr = '0; i_req_len = '0; d_req_len = '0;
    ar_ready = 1'b1;
    r_valid = 1'b0; r_data = '0; r_last = 1'b0; r_resp = 2'b00;
    do_reset();

    // Single ICACHE refill, two OKAY beats 0x11 / 0x22.
    txn(1'b1, 1'b0, 1'b0, 64'h8000_0000, 8'd1, 2, 64'h11, -1, 0, -1);

    // Contention from reset: I, then D on the next cycle, then I again.
    do_reset();
    txn(1'b1, 1'b1, 1'b0, 64'h8000_0100, 8'd1, 2, 64'h100, -1, 0, -1);
    txn(1'b0, 1'b1, 1'b1, 64'h8000_0100, 8'd1, 2, 64'h200, -1, 0, -1);
    txn(1'b1, 1'b1, 1'b0, 64'h8000_0100, 8'd0, 1, 64'h300, -1, 0, -1);
    d_req_valid = 1'b0;

    // AR stalled for five cycles.
    txn(1'b1, 1'b0, 1'b0, 64'h8000_2000, 8'd3, 4, 64'h400, -1, 5, -1);

    // Early r_last (len 3, two beats), then a clean DCACHE burst.
    txn(1'b1, 1'b0, 1'b0, 64'h8000_3000, 8'd3, 2, 64'h500, -1, 0, -1);
    txn(1'b0, 1'b1, 1'b1, 64'h8000_3000, 8'd1, 2, 64'h600, -1, 0, -1);

    // Overrun: len 0 but r_last only on the second beat.
    txn(1'b0, 1'b1, 1'b1, 64'h8000_4000, 8'd0, 2, 64'h700, -1, 0, -1);

    // SLVERR on the middle beat of three.
    txn(1'b1, 1'b0, 1'b0, 64'h8000_5000, 8'd2, 3, 64'h800, 1, 0, -1);

    // Reset during beat 2 of 4; priority was on DCACHE and must return to ICACHE.
    txn(1'b1, 1'b0, 1'b0, 64'h8000_6000, 8'd3, 4, 64'h900, -1, 0, 1);
    txn(1'b1, 1'b1, 1'b0, 64'h8000_7000, 8'd1, 2, 64'hA00, -1, 0, -1);
    d_req_valid = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("idle_ar_valid", 64'(ar_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22041461_refill_arbiter.md
# ysyx_22041461_refill_arbiter

Shares one downstream AXI-style read channel (AR/R) between the instruction-cache refill path and the data-cache refill path. It accepts one refill request at a time, issues the address, and streams returned beats back to the requester that owns the transaction. Fairness is round-robin. The block sits between the two caches' miss logic and the memory/bus interface.

## Interface
Parameters:
- ADDR_W, 64, request/AR address width
- DATA_W, 64, R data width
- LEN_W, 8, burst length field width (AXI encoding: beats − 1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  ICACHE refill request
- i_req_addr  in  ADDR_W  ICACHE refill address; stable while i_req_valid
- i_req_len  in  LEN_W  ICACHE burst length − 1
- i_req_ready  out  1  ICACHE request accepted this cycle
- i_resp_valid  out  1  beat for ICACHE
- d_req_valid / d_req_addr / d_req_len / d_req_ready  same as the i_* request ports, for DCACHE
- d_resp_valid  out  1  beat for DCACHE
- resp_data  out  DATA_W  shared beat data (qualified by i_/d_resp_valid)
- resp_last  out  1  final beat of the transaction
- resp_err  out  1  valid with resp_last; transaction had an error
- ar_valid, ar_ready  out/in  1  address handshake
- ar_addr  out  ADDR_W; ar_len  out  LEN_W; ar_id  out  1 (0 = ICACHE, 1 = DCACHE)
- r_valid  in  1; r_ready  out  1; r_data  in  DATA_W; r_last  in  1; r_resp  in  2

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE**
  - If any req_valid is high, the 2-way round-robin picks a winner. With both requesting, the requester not granted last wins.
  - The winner's req_ready is asserted combinationally.
  - Latch addr, len and owner; go to ADDR.
  - If no req_valid is high, stay in IDLE.
- **ADDR**
  - ar_valid = 1; ar_addr, ar_len and ar_id come from the latched values and are held stable until ar_ready.
  - On ar_valid & ar_ready, go to DATA and clear the beat counter.
- **DATA**
  - r_ready = 1.
  - Each r_valid beat passes through combinationally:
    - owner's resp_valid = r_valid;
    - resp_data = r_data;
    - resp_last = r_last.
  - The non-owner's resp_valid stays 0.
  - Beat counter (LEN_W+1 bits) increments per beat.
  - Error flag is set, and stays set until the end of the transaction, when:
    - r_resp ≠ 0 on any beat;
    - r_last arrives with counter ≠ latched len;
    - counter passes len without r_last.
  - resp_err = (error flag | current beat's error) on the r_last beat.
  - On the r_last beat:
    - go to IDLE;
    - the round-robin pointer now favours the other requester;
    - clear the error flag.
- Requester responses have no backpressure; caches must accept every beat.
- Outputs forced 0 outside their states: req_ready is 0 except in IDLE, ar_valid is 0 except in ADDR, r_ready is 0 except in DATA.
- Reset (at any time, including mid-burst):
  - state → IDLE;
  - round-robin pointer favours ICACHE;
  - counter and error flag cleared;
  - all outputs 0.
  - No partial response is replayed after reset.

## Timing
- A request accepted in cycle t puts ar_valid high in cycle t+1.
- If ar_ready is high in t+1, r_ready is high from t+2.
- Beat-to-requester latency is 0 cycles (combinational pass-through).
- After the r_last beat in cycle t, the state is IDLE in t+1 and a new request can be accepted in t+1. This gives a minimum of 1 dead cycle between bursts on AR.
- Both requesters valid in the same cycle: exactly one req_ready. The other stays unaccepted and is served next, provided its valid is held.
- A requester dropping valid before ready is tolerated; no grant is latched for it.

## Structure
- Shared package ysyx_22041461_pkg:
  - state enum {IDLE, ADDR, DATA};
  - owner IDs OWNER_I = 0, OWNER_D = 1;
  - RESP_OKAY = 2'b00.
- Sub-module ysyx_22041461_rr_arb2 (the 2-way round-robin arbiter):
  - inputs: two request bits, enable, update pulse;
  - outputs: one-hot grant and a priority pointer register (async reset to ICACHE priority).
- Top level holds the FSM, the address/len/owner latches, the beat counter, the error flag and the response steering.

## Test plan
- Single ICACHE request, addr 0x8000_0000, len 1, ar_ready immediate, two OKAY beats 0x11/0x22 with last on beat 2 → exactly 2 i_resp_valid pulses with those data; resp_last on the second; resp_err = 0; d_resp_valid always 0; ar_id = 0.
- Both requesters valid from reset → ICACHE served first (ar_id 0). After its r_last, DCACHE is accepted the next cycle (ar_id 1). Then ICACHE again on a third simultaneous request.
- ar_ready held low for 5 cycles → ar_valid, ar_addr and ar_len stay constant for all 5 cycles; no r_ready until after the handshake.
- len = 3, but r_last on beat 2 → transaction ends on that beat with resp_err = 1. A subsequent clean burst reports resp_err = 0.
- r_resp = 2'b10 on the middle beat of a 3-beat burst → all 3 beats forwarded; resp_err = 1 on the last.
- rst asserted mid-DATA after beat 1 of 4 → all outputs 0 immediately; IDLE after release; next request is ICACHE-priority and completes normally.
